// File: rtl/word_serializer_pkg.sv
// Shared widths and state encodings for the word-to-byte serializer.
package word_serializer_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/word_serializer_splitter.sv
// Existing 32-bit byte splitter: O1 is the most significant byte, O4 the least.
module word_serializer_splitter
  import word_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  output logic [BYTE_W-1:0] o1,
  output logic [BYTE_W-1:0] o2,
  output logic [BYTE_W-1:0] o3,
  output logic [BYTE_W-1:0] o4
);

  assign o1 = a[31:24];
  assign o2 = a[23:16];
  assign o3 = a[15:8];
  assign o4 = a[7:0];

endmodule

// File: rtl/word_serializer.sv
// Holds one accepted word and streams its four bytes out over a valid/ready
// byte interface, allowing a new word to load on the last byte transfer.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] hold_q, hold_d;

  logic             sending;
  logic             at_last;
  logic             accept;
  logic             xfer;
  logic [IDX_W-1:0] sel;
  byte_t            o1, o2, o3, o4;
  byte_t            mux_byte;

  assign sending = (state_q == ST_SEND);
  assign at_last = (idx_q == IDX_LAST);

  // in_ready depends combinationally on out_ready so a new word can load on
  // the last byte transfer without a bubble; it is forced low during reset.
  assign in_ready  = reset & (~sending | (at_last & out_ready));
  assign out_valid = sending;
  assign busy      = sending;
  assign out_last  = sending & at_last;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  word_serializer_splitter u_splitter (
    .a  (hold_q),
    .o1 (o1),
    .o2 (o2),
    .o3 (o3),
    .o4 (o4)
  );

  // sel 0 always picks O1; LSB-first order is the index reversed.
  assign sel = MSB_FIRST ? idx_q : ~idx_q;

  always_comb begin
    mux_byte = o1;
    case (sel)
      2'd0: mux_byte = o1;
      2'd1: mux_byte = o2;
      2'd2: mux_byte = o3;
      2'd3: mux_byte = o4;
      default: mux_byte = o1;
    endcase
  end

  assign out_byte = sending ? mux_byte : '0;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hold_d  = in_word;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (accept) begin
            hold_d = in_word;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the holding register is reset too, so out_byte is
  // defined from the first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share stimulus;
// expected bytes are queued at issue time and popped by a per-instance monitor.
module tb_word_serializer;

  logic        clk;
  logic        reset;
  logic [31:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_out_byte;
  logic        l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [7:0]  l_out_byte;

  int checks;
  int errors;

  logic [8:0] q_m[$];
  logic [8:0] q_l[$];

  word_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_byte(m_out_byte), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_last(m_out_last), .busy(m_busy)
  );

  word_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_byte(l_out_byte), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_last(l_out_last), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every byte transfer against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && m_out_valid && out_ready) begin
      if (q_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected_byte: got %0h expected none at %0t", m_out_byte, $time);
      end else begin
        logic [8:0] e;
        e = q_m.pop_front();
        check("m_byte", m_out_byte, e[7:0]);
        check("m_last", m_out_last, e[8]);
        check("m_busy", m_busy, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && l_out_valid && out_ready) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l_unexpected_byte: got %0h expected none at %0t", l_out_byte, $time);
      end else begin
        logic [8:0] e;
        e = q_l.pop_front();
        check("l_byte", l_out_byte, e[7:0]);
        check("l_last", l_out_last, e[8]);
        check("l_busy", l_busy, 1);
      end
    end
  end

  task automatic push_expected(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      q_m.push_back({(k == 3), w[31-8*k -: 8]});
      q_l.push_back({(k == 3), w[8*k +: 8]});
    end
  endtask

  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] w, input bit drop_valid);
    bit got;
    push_expected(w);
    in_word  = w;
    in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (m_in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got 0 expected 1 at %0t", $time);
    end
    if (drop_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_m", q_m.size(), 0);
    check("drain_l", q_l.size(), 0);
    q_m.delete();
    q_l.delete();
  endtask

  initial begin
    int acc_at;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_word   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_last",  m_out_last, 0);
    check("rst_busy",      m_busy, 0);
    check("rst_out_byte",  m_out_byte, 8'h00);
    check("rst_in_ready",  m_in_ready, 0);
    check("rst_l_in_ready", l_in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", m_in_ready, 1);
    @(posedge clk);
    #1;

    // Single word, both byte orders.
    send_word(32'hDCF00731, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_valid", m_out_valid, 1);
      @(posedge clk);
      #1;
    end
    wait_drain();
    @(negedge clk);
    check("single_done_valid", m_out_valid, 0);
    check("single_done_ready", m_in_ready, 1);
    check("single_done_l_valid", l_out_valid, 0);
    @(posedge clk);
    #1;

    // Backpressure on the first byte.
    out_ready = 1'b0;
    send_word(32'h11223344, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",  m_out_valid, 1);
      check("bp_byte_m", m_out_byte, 8'h11);
      check("bp_byte_l", l_out_byte, 8'h44);
      check("bp_last",   m_out_last, 0);
      check("bp_in_ready", m_in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back words with in_valid held high.
    send_word(32'hAABBCCDD, 1'b0);
    push_expected(32'h01020304);
    in_word = 32'h01020304;
    acc_at  = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", m_out_valid, 1);
      if (i < 7) check("b2b_in_ready", m_in_ready, (i == 3));
      if (in_valid && m_in_ready) acc_at = i;
      @(posedge clk);
      #1;
      if (acc_at == i) in_valid = 1'b0;
    end
    check("b2b_accept_cycle", acc_at, 3);
    in_valid = 1'b0;
    wait_drain();

    // Reset asserted between edges after byte F0.
    send_word(32'hDCF00731, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_valid", m_out_valid, 1);
    check("pre_rst_byte",  m_out_byte, 8'h07);
    reset = 1'b0;
    #1;
    check("midrst_valid_m", m_out_valid, 0);
    check("midrst_valid_l", l_out_valid, 0);
    check("midrst_in_ready", m_in_ready, 0);
    check("midrst_remaining", q_m.size(), 2);
    q_m.delete();
    q_l.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid", m_out_valid, 0);
      @(posedge clk);
      #1;
    end

    // in_word changes while a word is held.
    send_word(32'hCAFEBABE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      in_word = $urandom;
      @(posedge clk);
      #1;
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Downstream stage of the 32-bit byte splitter: accepts one 32-bit word per valid/ready handshake and emits its four bytes, one per cycle, on an 8-bit valid/ready stream.
- Byte selection reuses the existing splitter. The block adds the holding register, byte counter and handshake control around it.
- Used wherever a word-wide producer (register file read, memory data) feeds a byte-wide consumer.

Parameters:
- MSB_FIRST, 1: 1 = emit O1 (bits 31:24) first, then O2, O3, O4. 0 = emit O4 (bits 7:0) first, then O3, O2, O1.

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- in_word  input  32  word to serialize, sampled on accept
- in_valid  input  1  in_word is valid
- in_ready  output  1  block can accept a word this cycle
- out_byte  output  8  current byte
- out_valid  output  1  out_byte is valid
- out_ready  input  1  consumer takes out_byte this cycle
- out_last  output  1  out_byte is the 4th byte of its word (qualified by out_valid)
- busy  output  1  a word is held (equal to out_valid)

Behaviour:
- State: hold_q[31:0], idx_q[1:0], state ∈ {IDLE, SEND}.
- Reset (reset=0, asynchronous): state=IDLE, idx_q=0, hold_q=0. Outputs: out_valid=0, out_last=0, busy=0, out_byte=0x00, in_ready=0 while reset is low, 1 in IDLE after release.
- Word accept: in_valid & in_ready at a rising edge.
- Byte transfer: out_valid & out_ready at a rising edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: hold_q<=in_word, idx_q<=0, go to SEND.
- SEND:
  - out_valid=1. out_byte = splitter output selected by idx_q, with order set by MSB_FIRST.
  - out_last = (idx_q==3).
  - Transfer with idx_q<3: idx_q<=idx_q+1.
  - Transfer with idx_q==3 and no accept: go to IDLE, idx_q<=0.
- Back-to-back:
  - in_ready = IDLE | (SEND & idx_q==3 & out_ready). This is a combinational out_ready->in_ready path and is permitted.
  - Accept in the same cycle as the last transfer: load hold_q, idx_q<=0, stay in SEND. Byte 0 of the new word is valid the next cycle, so there is no bubble.
- Latency: word accepted at edge N -> byte 0 valid after edge N. Byte k valid after edge N+k when out_ready is held high. Sustained throughput is 4 bytes per 4 cycles.
- Backpressure: out_ready=0 holds out_byte, out_last and idx_q stable. out_valid never drops until the byte transfers.
- in_valid while busy and not on the last transfer: not accepted. The producer holds the word.
- in_word changing while held: no effect, because hold_q is isolated from in_word.
- Reset mid-word: the remaining bytes are discarded, and no partial output follows reset release.
- idx_q wraps 3->0 only on the last transfer. It has no other modulo behaviour.

Decomposition:
- Shared package/include: BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, state encodings ST_IDLE=1'b0, ST_SEND=1'b1.
- Sub-module: the existing splitter (A -> O1..O4) instantiated on hold_q. The block adds a 4:1 byte mux on idx_q.
- No other sub-modules.

Test Plan:
- Reset then single word:
  - Stimulus: hold reset low 3 cycles, release; in_word=0xDCF00731, in_valid for 1 cycle, out_ready=1, MSB_FIRST=1.
  - Required: out_byte DC, F0, 07, 31 on 4 consecutive cycles; out_last only on 31; then out_valid=0 and in_ready=1.
- LSB order:
  - Stimulus: MSB_FIRST=0, same word.
  - Required: out_byte 31, 07, F0, DC.
- Backpressure:
  - Stimulus: word 0x11223344; out_ready=0 for 5 cycles after the first byte appears.
  - Required: out_byte stays 0x11 and out_valid stays 1 throughout; on release, 22, 33, 44 follow with no loss or duplication.
- Back-to-back:
  - Stimulus: in_valid held high with words 0xAABBCCDD then 0x01020304; out_ready=1.
  - Required: AA BB CC DD 01 02 03 04 on 8 consecutive cycles; in_ready=1 only in the cycles of DD (and the initial IDLE cycle).
- Reset mid-word:
  - Stimulus: assert reset asynchronously (between edges) after byte 0xF0 of 0xDCF00731.
  - Required: out_valid=0 immediately, before the next edge; after release, no byte is emitted until a new word is accepted.
- Held input isolation:
  - Stimulus: change in_word every cycle during SEND.
  - Required: emitted bytes match the word captured at accept.
